// File: rtl/flag_register_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : flag_register_unit_if
// Brief    : Control/status bundle between the core and the flag register unit.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface flag_register_unit_if #(
    parameter int CNT_W = 3
);
    logic [3:0]       flags_in;
    logic             flags_we;
    logic             push;
    logic             pop;
    logic             clr_err;
    logic [3:0]       cond;
    logic [3:0]       flags_out;
    logic             cond_pass;
    logic [CNT_W-1:0] stack_count;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;

    modport master (
        output flags_in, flags_we, push, pop, clr_err, cond,
        input  flags_out, cond_pass, stack_count, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  flags_in, flags_we, push, pop, clr_err, cond,
        output flags_out, cond_pass, stack_count, stack_full, stack_empty, stack_err
    );
endinterface
`default_nettype wire

// File: rtl/flag_register_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : flag_register_unit
// Brief    : {V,Z,N,C} flag register with LIFO save stack and condition evaluator.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module flag_register_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    flag_register_unit_if.slave   bus
);
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_count;
    logic             r_err;
    logic [3:0]       r_stack [DEPTH];

    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic               w_err_evt;
    logic [CNT_W-1:0]   w_cnt_m1;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_v, w_z, w_n, w_c;
    logic               w_pass;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push_ok = bus.push & ~bus.pop & ~w_full;
    assign w_pop_ok  = bus.pop & ~bus.push & ~w_empty;
    // Any stack strobe that is not a legal push or pop is an error.
    assign w_err_evt = (bus.push | bus.pop) & ~w_push_ok & ~w_pop_ok;
    assign w_cnt_m1  = r_count - CNT_W'(1);
    assign w_wr_idx  = r_count[c_IDX_W-1:0];
    assign w_rd_idx  = w_cnt_m1[c_IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 4'b0000;
            r_count <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= 4'b0000;
            end
        end else begin
            if (w_pop_ok) begin
                r_flags <= r_stack[w_rd_idx];
                r_count <= w_cnt_m1;
            end else begin
                if (bus.flags_we) begin
                    r_flags <= bus.flags_in;
                end
                if (w_push_ok) begin
                    r_stack[w_wr_idx] <= r_flags;
                    r_count           <= r_count + CNT_W'(1);
                end
            end
            if (w_err_evt) begin
                r_err <= 1'b1;
            end else if (bus.clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign {w_v, w_z, w_n, w_c} = r_flags;

    always_comb begin
        w_pass = 1'b0;
        case (bus.cond)
            4'd0:    w_pass = w_z;
            4'd1:    w_pass = ~w_z;
            4'd2:    w_pass = w_c;
            4'd3:    w_pass = ~w_c;
            4'd4:    w_pass = w_n;
            4'd5:    w_pass = ~w_n;
            4'd6:    w_pass = w_v;
            4'd7:    w_pass = ~w_v;
            4'd8:    w_pass = w_c & ~w_z;
            4'd9:    w_pass = ~w_c | w_z;
            4'd10:   w_pass = (w_n == w_v);
            4'd11:   w_pass = (w_n != w_v);
            4'd12:   w_pass = ~w_z & (w_n == w_v);
            4'd13:   w_pass = w_z | (w_n != w_v);
            4'd14:   w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    assign bus.flags_out   = r_flags;
    assign bus.cond_pass   = w_pass;
    assign bus.stack_count = r_count;
    assign bus.stack_full  = w_full;
    assign bus.stack_empty = w_empty;
    assign bus.stack_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_flag_register_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_flag_register_unit
// Brief    : Directed self-checking bench for flag_register_unit (DEPTH=4).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_flag_register_unit;
    localparam int c_DEPTH = 4;
    localparam int c_CNT_W = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    flag_register_unit_if #(.CNT_W(c_CNT_W)) bus ();

    flag_register_unit #(.DEPTH(c_DEPTH), .CNT_W(c_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        bus.flags_in = v;
        bus.flags_we = 1'b1;
        step();
        bus.flags_we = 1'b0;
    endtask

    task automatic do_push();
        bus.push = 1'b1;
        step();
        bus.push = 1'b0;
    endtask

    task automatic do_pop();
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
    endtask

    // Paired codes: even code picks a base predicate, odd code is its inverse.
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
        logic v, z, n, cy, base;
        {v, z, n, cy} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n ~^ v);
            3'd6:    base = !z && (n ~^ v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst          = 1'b1;
        bus.flags_in = 4'b0000;
        bus.flags_we = 1'b0;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.clr_err  = 1'b0;
        bus.cond     = 4'd0;
        #12;
        check("rst_flags", bus.flags_out, 4'b0000);
        check("rst_count", bus.stack_count, 0);
        check("rst_empty", bus.stack_empty, 1);
        check("rst_full",  bus.stack_full, 0);
        check("rst_err",   bus.stack_err, 0);
        rst = 1'b0;
        step();

        // Load and basic conditions
        load(4'b0101);
        check("load_flags", bus.flags_out, 4'b0101);
        bus.cond = 4'd0; #1; check("cond_eq", bus.cond_pass, 1);
        bus.cond = 4'd2; #1; check("cond_cs", bus.cond_pass, 1);
        bus.cond = 4'd4; #1; check("cond_mi", bus.cond_pass, 0);

        // Push/pop round trip
        load(4'b1001);
        do_push();
        check("rt_count1", bus.stack_count, 1);
        load(4'b0100);
        check("rt_loaded", bus.flags_out, 4'b0100);
        do_pop();
        check("rt_popped", bus.flags_out, 4'b1001);
        check("rt_count0", bus.stack_count, 0);
        check("rt_empty",  bus.stack_empty, 1);

        // Push with simultaneous write
        load(4'b0010);
        bus.flags_in = 4'b1100;
        bus.flags_we = 1'b1;
        bus.push     = 1'b1;
        step();
        bus.flags_we = 1'b0;
        bus.push     = 1'b0;
        check("pw_flags", bus.flags_out, 4'b1100);
        check("pw_count", bus.stack_count, 1);
        do_pop();
        check("pw_restore", bus.flags_out, 4'b0010);

        // Fill to full; stack receives 0010,0001,0010,0011; register ends at 0100
        for (int i = 0; i < c_DEPTH; i++) begin
            bus.flags_in = 4'(i + 1);
            bus.flags_we = 1'b1;
            bus.push     = 1'b1;
            step();
        end
        bus.flags_we = 1'b0;
        bus.push     = 1'b0;
        check("full_count", bus.stack_count, 4);
        check("full_flag",  bus.stack_full, 1);
        check("full_noerr", bus.stack_err, 0);
        check("full_flags", bus.flags_out, 4'b0100);
        bus.flags_in = 4'b1111;
        bus.flags_we = 1'b1;
        bus.push     = 1'b1;
        step();
        bus.flags_we = 1'b0;
        bus.push     = 1'b0;
        check("ovf_count", bus.stack_count, 4);
        check("ovf_err",   bus.stack_err, 1);
        check("ovf_we",    bus.flags_out, 4'b1111);
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        check("clr_err", bus.stack_err, 0);
        do_pop(); check("lifo_3", bus.flags_out, 4'b0011);
        do_pop(); check("lifo_2", bus.flags_out, 4'b0010);
        do_pop(); check("lifo_1", bus.flags_out, 4'b0001);
        // Pop with a concurrent write must discard the write
        bus.flags_in = 4'b1110;
        bus.flags_we = 1'b1;
        do_pop();
        bus.flags_we = 1'b0;
        check("lifo_0",     bus.flags_out, 4'b0010);
        check("lifo_empty", bus.stack_empty, 1);
        do_pop();
        check("udf_err",   bus.stack_err, 1);
        check("udf_flags", bus.flags_out, 4'b0010);
        check("udf_count", bus.stack_count, 0);

        // Error wins over clr_err in the same cycle
        bus.clr_err = 1'b1;
        do_pop();
        check("err_wins", bus.stack_err, 1);
        step();
        bus.clr_err = 1'b0;
        check("err_clr2", bus.stack_err, 0);

        // Push+pop together with write
        load(4'b1000);
        do_push();
        bus.flags_in = 4'b0001;
        bus.flags_we = 1'b1;
        bus.push     = 1'b1;
        bus.pop      = 1'b1;
        step();
        bus.flags_we = 1'b0;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        check("pp_count", bus.stack_count, 1);
        check("pp_err",   bus.stack_err, 1);
        check("pp_flags", bus.flags_out, 4'b0001);

        // Condition sweep
        for (int f = 0; f < 16; f++) begin
            load(4'(f));
            for (int c = 0; c < 16; c++) begin
                bus.cond = 4'(c);
                #1;
                check($sformatf("cond_f%0d_c%0d", f, c), bus.cond_pass, ref_cond(4'(f), 4'(c)));
            end
            step();
        end

        // Asynchronous reset mid-operation
        do_push();
        do_push();
        check("pre_rst_count", bus.stack_count, 3);
        #2;
        rst = 1'b1;
        bus.push = 1'b1;
        #1;
        check("async_count", bus.stack_count, 0);
        check("async_flags", bus.flags_out, 4'b0000);
        check("async_err",   bus.stack_err, 0);
        step();
        check("rst_hold_count", bus.stack_count, 0);
        bus.push = 1'b0;
        rst = 1'b0;
        step();
        check("post_rst_empty", bus.stack_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/flag_register_unit.md
Name: flag_register_unit

Overview:
- Sequential consumer of the 4-bit ALU status word (bit3 V overflow, bit2 Z zero, bit1 N negative, bit0 C carry) produced by the arithmetic/other status logic.
- Holds the architectural flag register and a LIFO flag stack, used to save and restore flags across calls and interrupts.
- Evaluates a 4-bit condition code against the registered flags for conditional branch and execute decisions.

Parameters:
- DEPTH, 4, number of flag stack entries (≥2).
- CNT_W, $clog2(DEPTH+1), width of the stack occupancy count.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- flags_in  input  4  status word from the status stage {V,Z,N,C}.
- flags_we  input  1  load flags_in into the flag register at the next edge.
- push  input  1  save the current flag register onto the stack.
- pop  input  1  restore the flag register from the stack top.
- clr_err  input  1  clear the sticky stack_err.
- cond  input  4  condition code to evaluate.
- flags_out  output  4  registered flag value {V,Z,N,C}.
- cond_pass  output  1  condition result for cond against flags_out.
- stack_count  output  CNT_W  number of valid stack entries.
- stack_full  output  1  stack_count == DEPTH.
- stack_empty  output  1  stack_count == 0.
- stack_err  output  1  sticky illegal-stack-operation flag.

Behaviour:
- Reset (async, rst=1): flags_out=0000, stack_count=0, stack_err=0, stack entries=0; stack_empty=1, stack_full=0.
- Flag register update priority at each rising edge:
  - Legal pop: load the stack top.
  - Otherwise, flags_we: load flags_in.
  - Otherwise: hold.
- Latency: flags_out reflects flags_in or the popped value 1 cycle after the strobe.
- Legal push (push=1, pop=0, not full):
  - Writes the pre-edge flags_out into entry[stack_count]; stack_count+1.
  - With flags_we in the same cycle: the stack gets the old value and the register gets flags_in.
- Legal pop (pop=1, push=0, not empty):
  - flags_out <= entry[stack_count-1]; stack_count-1.
  - A flags_we in the same cycle is discarded.
- Push when full: stack unchanged, stack_err<=1; flags_we still honoured.
- Pop when empty: stack unchanged, stack_err<=1; flags_we still honoured.
- push and pop together: both ignored, stack_err<=1; flags_we still honoured.
- stack_err clearing:
  - Sticky; cleared by clr_err at the next edge.
  - If a new error occurs in the same cycle as clr_err, the error wins (stays 1).
- stack_full / stack_empty: combinational decode of the registered stack_count.
- cond_pass: combinational from cond and the registered flags_out (zero extra latency).
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 NV 0
- Reset asserted mid-operation: immediate return to the reset state, stack contents discarded; pending strobes are not honoured until rst deasserts.
- No X propagation: stack entries at or above stack_count are never driven onto flags_out.

Test Plan:
- Reset then load: rst pulse, flags_in=4'b0101, flags_we=1 for 1 cycle → flags_out=0101 next cycle; cond=0 (EQ) gives cond_pass=1, cond=2 (CS) gives 1, cond=4 (MI) gives 0.
- Push/pop round trip: flags=1001, push → count=1; load 0100; pop → flags_out=1001, count=0, stack_empty=1.
- Push with simultaneous write: flags=0010, push+flags_we with flags_in=1100 → flags_out=1100, stack top=0010; pop then restores 0010.
- Overflow/underflow: DEPTH=4 pushes → stack_full=1; 5th push → count stays 4, stack_err=1. clr_err → 0. Pop on empty → stack_err=1, flags_out unchanged.
- Simultaneous push+pop with flags_we (flags_in=0001) → count unchanged, stack_err=1, flags_out=0001.
- Condition sweep: all 16 flag values × 16 cond codes versus the reference table; also async rst asserted with count=3 → count=0 and flags_out=0000 without waiting for a clock edge.
